key_pulse: RTL and testbench

KEY_PULSE -- requirements
Module: key_pulse

---
 rtl/key_pulse.sv | 154 +++++++++++++++
 tb/tb_key_pulse.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/key_pulse.sv
// key_pulse: debounces a synchronised key level and emits single-cycle flap
// pulses on each accepted press and on auto-repeat while the key stays held.
//
// state        | meaning
// -------------|---------------------------------------------------------
// IDLE         | key released and accepted low
// PRESS_WAIT   | counting consecutive high samples before accepting a press
// HELD         | key accepted high; repeat timer running
// RELEASE_WAIT | counting consecutive low samples before accepting release
module key_pulse #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_DELAY    = 10,
   parameter int unsigned REPEAT_PERIOD   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       press,
   input  logic       enable,
   output logic       flap,
   output logic       held,
   output logic [7:0] flap_count
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // 9-bit compare values so counter+1 never wraps before the compare
   localparam logic [8:0] DEB_N = 9'(DEBOUNCE_CYCLES);
   localparam logic [8:0] RD_N  = 9'(REPEAT_DELAY);
   localparam logic [7:0] RP_N  = 8'(REPEAT_PERIOD);

   state_t     state_q, state_d;
   logic [7:0] deb_q, deb_d;
   logic [7:0] rpt_q, rpt_d;
   logic [7:0] per_q, per_d;
   logic       held_q, held_d;
   logic       flap_q, flap_d;
   logic [7:0] count_q, count_d;
   logic       evt;
   logic [8:0] deb_inc;
   logic [8:0] rpt_inc;

   // Next-state, counters and pulse qualification
   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      rpt_d   = rpt_q;
      per_d   = per_q;
      held_d  = held_q;
      evt     = 1'b0;
      deb_inc = {1'b0, deb_q} + 9'd1;
      rpt_inc = {1'b0, rpt_q} + 9'd1;
      case (state_q)
         IDLE: begin
            if (press) begin
               if (DEB_N == 9'd1) begin
                  state_d = HELD;
                  held_d  = 1'b1;
                  rpt_d   = 8'd0;
                  evt     = 1'b1;
               end else begin
                  state_d = PRESS_WAIT;
                  deb_d   = 8'd1;
               end
            end
         end
         PRESS_WAIT: begin
            if (!press) begin
               state_d = IDLE;
            end else if (deb_inc == DEB_N) begin
               // this edge takes the last required high sample
               state_d = HELD;
               held_d  = 1'b1;
               rpt_d   = 8'd0;
               evt     = 1'b1;
            end else begin
               deb_d = deb_inc[7:0];
            end
         end
         HELD: begin
            if (!press) begin
               if (DEB_N == 9'd1) begin
                  state_d = IDLE;
                  held_d  = 1'b0;
               end else begin
                  state_d = RELEASE_WAIT;
                  deb_d   = 8'd1;
               end
            end else begin
               rpt_d = (rpt_q == 8'hFF) ? 8'hFF : rpt_inc[7:0];
               if (RD_N != 9'd0) begin
                  if (rpt_inc == RD_N) begin
                     evt   = 1'b1;
                     per_d = RP_N;
                  end else if ({1'b0, rpt_q} >= RD_N) begin
                     // period timer keeps running after rpt saturates
                     if (per_q <= 8'd1) begin
                        evt   = 1'b1;
                        per_d = RP_N;
                     end else begin
                        per_d = per_q - 8'd1;
                     end
                  end
               end
            end
         end
         RELEASE_WAIT: begin
            if (press) begin
               state_d = HELD;
               rpt_d   = 8'd0;
            end else if (deb_inc == DEB_N) begin
               state_d = IDLE;
               held_d  = 1'b0;
            end else begin
               deb_d = deb_inc[7:0];
            end
         end
         default: state_d = IDLE;
      endcase
      // guard keeps flap single-cycle even for degenerate repeat settings
      flap_d  = evt & enable & ~flap_q;
      count_d = count_q + {7'd0, flap_d};
   end

   // State and output registers, cleared asynchronously by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         deb_q   <= 8'd0;
         rpt_q   <= 8'd0;
         per_q   <= 8'd0;
         held_q  <= 1'b0;
         flap_q  <= 1'b0;
         count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         rpt_q   <= rpt_d;
         per_q   <= per_d;
         held_q  <= held_d;
         flap_q  <= flap_d;
         count_q <= count_d;
      end
   end

   assign flap       = flap_q;
   assign held       = held_q;
   assign flap_count = count_q;

endmodule

// File: tb/tb_key_pulse.sv
// Bench for key_pulse with default parameters. Expected flap edges are
// pushed to a queue when stimulus is driven; a negedge monitor pops them.
module tb_key_pulse;

   logic       clk;
   logic       reset;
   logic       press;
   logic       enable;
   logic       flap;
   logic       held;
   logic [7:0] flap_count;

   int n_checks = 0;
   int n_err    = 0;
   int edge_n   = 0;
   int exp_q[$];

   key_pulse dut (
      .clk        (clk),
      .reset      (reset),
      .press      (press),
      .enable     (enable),
      .flap       (flap),
      .held       (held),
      .flap_count (flap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   // Hold press at level p for n samples; returns at the negedge after
   // the n-th sampling edge.
   task automatic drive(input logic p, input int n);
      for (int i = 0; i < n; i++) begin
         press = p;
         @(negedge clk);
      end
   endtask

   // flap monitor against the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (flap) begin
            if (exp_q.size() == 0)
               check("flap_spurious", 1, 0);
            else if (exp_q[0] == edge_n)
               check("flap_edge", edge_n, exp_q.pop_front());
            else
               check("flap_edge", edge_n, exp_q[0]);
         end else if (exp_q.size() != 0 && exp_q[0] <= edge_n) begin
            check("flap_missing", 0, 1);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int s;
      reset  = 1'b1;
      press  = 1'b0;
      enable = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_flap", int'(flap), 0);
      check("rst_held", int'(held), 0);
      check("rst_count", int'(flap_count), 0);
      reset = 1'b0;
      @(negedge clk);

      // short glitch: 3 highs never accepted
      drive(1'b1, 3);
      drive(1'b0, 6);
      check("glitch_held", int'(held), 0);
      check("glitch_count", int'(flap_count), 0);

      // long press: accept at 4th sample, repeats 10/15/20 later
      s = edge_n;
      exp_q.push_back(s + 4);
      exp_q.push_back(s + 14);
      exp_q.push_back(s + 19);
      exp_q.push_back(s + 24);
      drive(1'b1, 26);
      check("hold_held", int'(held), 1);
      check("hold_count", int'(flap_count), 4);

      // 2-sample dropout: stays held, repeat timer restarts on return
      s = edge_n;
      drive(1'b0, 2);
      check("dropout_held", int'(held), 1);
      exp_q.push_back(s + 13);
      exp_q.push_back(s + 18);
      drive(1'b1, 16);
      check("dropout_count", int'(flap_count), 6);

      // release takes 4 low samples, then a fresh 4-sample press
      s = edge_n;
      drive(1'b0, 3);
      check("rel3_held", int'(held), 1);
      drive(1'b0, 1);
      check("rel4_held", int'(held), 0);
      exp_q.push_back(s + 8);
      drive(1'b1, 4);
      check("repress_held", int'(held), 1);
      drive(1'b0, 5);
      check("repress_count", int'(flap_count), 7);
      check("repress_rel", int'(held), 0);

      // enable low suppresses accept and first repeat, no catch-up later
      s = edge_n;
      enable = 1'b0;
      drive(1'b1, 14);
      check("dis_count", int'(flap_count), 7);
      check("dis_held", int'(held), 1);
      enable = 1'b1;
      exp_q.push_back(s + 19);
      exp_q.push_back(s + 24);
      drive(1'b1, 10);
      check("reen_count", int'(flap_count), 9);
      drive(1'b0, 5);

      // long press to flap_count=255, repeats continue past rpt saturation
      s = edge_n;
      exp_q.push_back(s + 4);
      for (int k = 0; k <= 244; k++) exp_q.push_back(s + 14 + 5 * k);
      drive(1'b1, 1234);
      check("long_count", int'(flap_count), 255);
      check("long_held", int'(held), 1);

      // async reset between edges with press still high
      #2 reset = 1'b1;
      #1;
      check("arst_flap", int'(flap), 0);
      check("arst_held", int'(held), 0);
      check("arst_count", int'(flap_count), 0);
      @(negedge clk);
      check("arst_q_empty", exp_q.size(), 0);
      reset = 1'b0;

      // press already high is debounced as a new press; 256 flaps wrap
      s = edge_n;
      exp_q.push_back(s + 4);
      for (int k = 0; k <= 254; k++) exp_q.push_back(s + 14 + 5 * k);
      drive(1'b1, 3);
      check("post_rst_held", int'(held), 0);
      drive(1'b1, 1);
      check("post_rst_accept", int'(held), 1);
      drive(1'b1, 1279);
      check("wrap_255", int'(flap_count), 255);
      drive(1'b1, 1);
      check("wrap_0", int'(flap_count), 0);
      drive(1'b0, 6);
      check("end_q_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
